// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder
//   Sequences 3x3 kernel weights and 7x7 image pixels out of a synchronous-read
//   memory into the con_5x5 core. Pixels go in the serpentine column-triple
//   order the core consumes. The stream is gap-free, and an idle gap follows
//   each frame so the core can drain before the next start is accepted.
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   start_i     begin a frame (ignored while busy_o)
//   load_w_i    sampled with start_i: 1 = 9 weights + 81 pixels, 0 = pixels only
//   rd_en_o     memory read strobe
//   rd_addr_o   memory read address
//   rd_data_i   memory read data, valid the cycle after rd_en_o
//   data_out_o  stream word (core data input)
//   ena_out_o   stream valid (core ena input)
//   busy_o      frame in progress or drain gap running
//   done_o      one-cycle pulse after the last stream word
module conv_stream_feeder #(
  parameter int DW     = 16,
  parameter int AW     = 8,
  parameter int W_BASE = 0,
  parameter int P_BASE = 9,
  parameter int GAP    = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          load_w_i,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [DW-1:0] rd_data_i,
  output logic [DW-1:0] data_out_o,
  output logic          ena_out_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {IDLE, WGT, FIRST, NEWROW, SWEEP, GAPW} state_t;

  state_t        state_q;
  logic [3:0]    w_q;      // weight index 0..8
  logic [1:0]    k_q;      // position inside a column triple
  logic [2:0]    c_q;      // column 1..7
  logic [2:0]    i_q;      // output row 1..5
  logic [GW-1:0] g_q;      // drain gap counter
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q;
  logic          ena_q;
  logic          busy_q;
  logic          done_q;
  logic [DW-1:0] hold_q;
  logic [DW-1:0] data_d;

  // Pixel address from (row, column). The row offset is a constant table, so
  // the path is two adds from the counters with no multiplier.
  function automatic logic [AW-1:0] pix(input logic [2:0] r, input logic [2:0] c);
    logic [5:0] roff;
    case (r)
      3'd2:    roff = 6'd7;
      3'd3:    roff = 6'd14;
      3'd4:    roff = 6'd21;
      3'd5:    roff = 6'd28;
      3'd6:    roff = 6'd35;
      3'd7:    roff = 6'd42;
      default: roff = 6'd0;
    endcase
    return AW'(P_BASE) + AW'(roff) + AW'(c) - AW'(1);
  endfunction

  // The memory's output register is the word's pipeline stage: ena_q is the
  // read strobe delayed by one, which lines up with rd_data_i. Outside a valid
  // beat the last word is held.
  always_comb begin
    data_d = hold_q;
    if (ena_q) data_d = rd_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      w_q       <= '0;
      k_q       <= '0;
      c_q       <= 3'd1;
      i_q       <= 3'd1;
      g_q       <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      ena_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hold_q    <= '0;
    end else begin
      ena_q  <= rd_en_q;
      // Reads are gap-free, so the first beat with no read behind it is the last.
      done_q <= ena_q & ~rd_en_q;
      hold_q <= data_d;
      case (state_q)
        IDLE: if (start_i) begin
          busy_q  <= 1'b1;
          rd_en_q <= 1'b1;
          w_q     <= '0;
          k_q     <= '0;
          c_q     <= 3'd1;
          i_q     <= 3'd1;
          if (load_w_i) begin
            state_q   <= WGT;
            rd_addr_q <= AW'(W_BASE);
          end else begin
            state_q   <= FIRST;
            rd_addr_q <= pix(3'd1, 3'd1);
          end
        end
        WGT: begin
          if (w_q == 4'd8) begin
            state_q   <= FIRST;
            rd_addr_q <= pix(3'd1, 3'd1);
          end else begin
            w_q       <= w_q + 4'd1;
            rd_addr_q <= rd_addr_q + AW'(1);
          end
        end
        // Rows 1..3, every column left to right.
        FIRST: begin
          if (k_q != 2'd2) begin
            k_q       <= k_q + 2'd1;
            rd_addr_q <= pix(3'(k_q) + 3'd2, c_q);
          end else if (c_q != 3'd7) begin
            k_q       <= '0;
            c_q       <= c_q + 3'd1;
            rd_addr_q <= pix(3'd1, c_q + 3'd1);
          end else begin
            state_q   <= NEWROW;
            i_q       <= 3'd2;
            c_q       <= 3'd5;
            rd_addr_q <= pix(3'd4, 3'd5);
          end
        end
        // New bottom row i+2: columns 5..7 for even i, 1..3 for odd i.
        NEWROW: begin
          if (c_q != (i_q[0] ? 3'd3 : 3'd7)) begin
            c_q       <= c_q + 3'd1;
            rd_addr_q <= pix(i_q + 3'd2, c_q + 3'd1);
          end else begin
            state_q   <= SWEEP;
            k_q       <= '0;
            c_q       <= 3'd4;
            rd_addr_q <= pix(i_q, 3'd4);
          end
        end
        // Column triples from column 4 outward: down to 1 for even i, up to 7 for odd i.
        SWEEP: begin
          if (k_q != 2'd2) begin
            k_q       <= k_q + 2'd1;
            rd_addr_q <= pix(i_q + 3'(k_q) + 3'd1, c_q);
          end else if (c_q != (i_q[0] ? 3'd7 : 3'd1)) begin
            k_q       <= '0;
            c_q       <= i_q[0] ? c_q + 3'd1 : c_q - 3'd1;
            rd_addr_q <= pix(i_q, i_q[0] ? c_q + 3'd1 : c_q - 3'd1);
          end else if (i_q == 3'd5) begin
            state_q <= GAPW;
            rd_en_q <= 1'b0;
          end else begin
            state_q   <= NEWROW;
            i_q       <= i_q + 3'd1;
            c_q       <= i_q[0] ? 3'd5 : 3'd1;
            rd_addr_q <= pix(i_q + 3'd3, i_q[0] ? 3'd5 : 3'd1);
          end
        end
        // Counting starts on the done beat so busy covers GAP idle cycles.
        GAPW: begin
          if (done_q || g_q != '0) begin
            if (g_q == GW'(GAP - 1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              g_q     <= '0;
            end else begin
              g_q <= g_q + GW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en_o    = rd_en_q;
  assign rd_addr_o  = rd_addr_q;
  assign data_out_o = data_d;
  assign ena_out_o  = ena_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: doc/conv_stream_feeder.md
# conv_stream_feeder

Upstream sequencer for the 3x3-kernel / 7x7-image convolution core (con_5x5). It reads kernel weights and image pixels from a synchronous-read memory and emits them as a contiguous 16-bit stream, in the serpentine column-triple order the core consumes. It drives the core's `data`/`ena` inputs directly and enforces the inter-frame idle gap the core needs to drain.

## Interface
- `DW`, default 16: data width.
- `AW`, default 8: memory address width.
- `W_BASE`, default 0: address of weight w[1][1]. Weights are row-major; w[r][c] is at W_BASE+(r-1)*3+(c-1).
- `P_BASE`, default 9: address of pixel p[1][1]. Pixels are row-major; p[r][c] is at P_BASE+(r-1)*7+(c-1).
- `GAP`, default 7: idle cycles after the last streamed word before a new start is accepted.

Ports:
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a frame. Sampled only when `busy`=0.
- `load_w` in 1: sampled with `start`. 1 sends 9 weights and then 81 pixels; 0 sends the 81 pixels only.
- `rd_en` out 1: memory read strobe.
- `rd_addr` out AW: memory read address.
- `rd_data` in DW: read data, valid exactly 1 cycle after `rd_en`.
- `data_out` out DW: stream word, to the core `data` input.
- `ena_out` out 1: stream valid, to the core `ena` input.
- `busy` out 1: high from start acceptance until the gap has expired.
- `done` out 1: one-cycle pulse after the last stream word.

## Operation
- States: IDLE, WGT, FIRST, NEWROW, SWEEP, GAPW.
- IDLE: when `start`=1, go to WGT if `load_w`=1, otherwise go to FIRST.
- WGT: 9 reads, w[1][1], w[1][2], … w[3][3].
- FIRST (output row i=1): column-major window for c=1..3, reading p[1][c], p[2][c], p[3][c] (9 reads). Then for c=4..7, read p[1][c], p[2][c], p[3][c] (12 reads).
- NEWROW (output row i=2..5): read the new bottom row r=i+2.
  - i even: columns 5, 6, 7.
  - i odd: columns 1, 2, 3.
- SWEEP (after each NEWROW): for each column, read rows i, i+1, i+2.
  - i even: columns c=4 down to 1.
  - i odd: columns c=4 up to 7.
- After i=5 SWEEP, go to GAPW. Frame word count is 90 with weights, 81 without.
- Counters:
  - triple index k (0..2);
  - column c (1..7);
  - output row i (1..5);
  - gap counter (0..GAP-1).
- Address arithmetic is unsigned and wraps at 2^AW. The pixel address is computed from r and c in one cycle, with no multiplier on the critical path; an incremental offset of ±1 / ±7 is acceptable.
- `data_out` holds its last value when `ena_out`=0.
- `start` while `busy`=1 is ignored; it is neither queued nor able to alter `load_w`.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. No `done` is generated. The in-flight read is discarded.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `data_out`=0, `ena_out`=0, `busy`=0, `done`=0.
- Start accepted at edge S:
  - `busy`=1 from S+1.
  - `rd_en`=1 on cycles S+1 … S+N, with one address per cycle and no bubbles.
- Each word appears as `data_out`=`rd_data` registered, so `ena_out`=1 on cycles S+2 … S+N+1. N consecutive cycles is a hard requirement.
- `done`=1 on cycle S+N+2 only.
- `busy` stays 1 through GAP cycles after the last `ena_out` cycle, i.e. it falls at S+N+2+GAP.
- A start on the first cycle with `busy`=0 is accepted.
- Latency from start to the first word is 2 cycles.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `start`=1. Required: all outputs 0 and no `rd_en`; after release, `busy` stays 0 until `start` is sampled.
- Full frame: memory returns data==address; pulse `start` with `load_w`=1. Required:
  - `ena_out` high for exactly 90 consecutive cycles;
  - words 1–9 = 0..8;
  - words 10–12 = 9, 16, 23;
  - word 31 = 34 (p[4][5]), words 34–36 = 19, 26, 33;
  - word 90 = 57;
  - `done` single pulse.
- Pixel-only frame: `load_w`=0. Required: 81 words, first word 9, word 22 = 34, last word 57; the whole sequence is checked against a golden serpentine model.
- Start during busy: assert `start` on every cycle of the frame and of the gap. Required: no second frame until `busy` falls; the next frame's first `ena_out` comes exactly 2 cycles after acceptance.
- Mid-frame reset: assert `rst` 40 cycles into the frame. Required: `ena_out`=0 and `busy`=0 the next cycle, no `done`; a subsequent `start` restarts from word 1.
- Parameter sweep: P_BASE=100, W_BASE=200. Required: first weight address 200 and last pixel address 148, with all pixel addresses in range 100..148.
